// File: rtl/ising_host_seq_pkg.sv
// rtl/ising_host_seq_pkg.sv - shared ising_axi register map, start word and host sequencer state encoding
package ising_host_seq_pkg;

    localparam logic [31:0] WEIGHT_ADDR_BASE = 32'h0001_0000;
    localparam logic [31:0] START_ADDR       = 32'h0000_000C;
    localparam logic [31:0] CTR_CUTOFF_ADDR  = 32'h0000_0004;
    localparam logic [31:0] CTR_MAX_ADDR     = 32'h0000_0008;
    localparam logic [31:0] PHASE_ADDR_BASE  = 32'h0000_0100;
    localparam logic [31:0] START_WORD       = 32'h0000_0010;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CFG_CUT,
        ST_CFG_MAX,
        ST_EDGE,
        ST_WR_IJ,
        ST_WR_JI,
        ST_VER_ADDR,
        ST_VER_CAP,
        ST_RUN_START,
        ST_RUN_WAIT,
        ST_RD_ADDR,
        ST_RD_CAP,
        ST_DONE
    } host_state_t;

endpackage

// File: rtl/ising_phase_reader.sv
// rtl/ising_phase_reader.sv - phase read index counter, capture and cutoff threshold into spin vector
module ising_phase_reader
#(
    parameter int N = 8
)
(
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                clear,
    input  logic                                capture,
    input  logic [31:0]                         rdata,
    input  logic [31:0]                         cutoff,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] index,
    output logic                                last,
    output logic [N-1:0]                        spins
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    assign last = (index == IW'(N - 1));

    // phase index 0 lands in the MSB of the spin vector
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index <= '0;
            spins <= '0;
        end else if (clear) begin
            index <= '0;
            spins <= '0;
        end else if (capture) begin
            spins[(N - 1) - int'(index)] <= (rdata >= cutoff);
            index <= last ? '0 : index + IW'(1);
        end
    end

endmodule

// File: rtl/ising_host_seq.sv
// rtl/ising_host_seq.sv - ising_axi host job sequencer; optional weight readback check under ISING_HOST_SEQ_VERIFY_EN
module ising_host_seq
    import ising_host_seq_pkg::*;
#(
    parameter int N           = 8,
    parameter int NUM_WEIGHTS = 3
)
(
    input  logic                                 clk,
    input  logic                                 axi_rstn,
    input  logic [31:0]                          cfg_cutoff,
    input  logic [31:0]                          cfg_max,
    input  logic [31:0]                          cfg_run_cycles,
    input  logic                                 start,
    input  logic                                 edge_valid,
    output logic                                 edge_ready,
    input  logic [((N > 1) ? $clog2(N) : 1)-1:0] edge_i,
    input  logic [((N > 1) ? $clog2(N) : 1)-1:0] edge_j,
    input  logic [NUM_WEIGHTS-1:0]               edge_w,
    input  logic                                 edge_last,
    output logic                                 wready,
    output logic [31:0]                          wr_addr,
    output logic [31:0]                          wdata,
    output logic [31:0]                          araddr,
    input  logic [31:0]                          rdata,
    output logic                                 busy,
    output logic                                 done,
    output logic [N-1:0]                         spins,
    output logic                                 err
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    host_state_t            state, state_next;
    logic [31:0]            cut_q, max_q, run_q, run_cnt;
    logic [IW-1:0]          e_i, e_j;
    logic [NUM_WEIGHTS-1:0] e_w;
    logic                   e_last;
    logic [IW-1:0]          phase_idx;
    logic                   phase_last;
    logic                   job_start;
    logic                   run_done;
    logic [31:0]            addr_ij, addr_ji;
    host_state_t            after_pair;

    assign job_start = (state == ST_IDLE) && start;
    assign run_done  = ({1'b0, run_cnt} + 33'd1) >= {1'b0, run_q};
    assign addr_ij   = WEIGHT_ADDR_BASE + (32'(e_i) << 2) + (32'(e_j) << 13);
    assign addr_ji   = WEIGHT_ADDR_BASE + (32'(e_j) << 2) + (32'(e_i) << 13);
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);

`ifdef ISING_HOST_SEQ_VERIFY_EN
    assign after_pair = ST_VER_ADDR;
`else
    assign after_pair = e_last ? ST_RUN_START : ST_EDGE;
`endif

    always_ff @(posedge clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            state   <= ST_IDLE;
            cut_q   <= '0;
            max_q   <= '0;
            run_q   <= '0;
            run_cnt <= '0;
            e_i     <= '0;
            e_j     <= '0;
            e_w     <= '0;
            e_last  <= 1'b0;
        end else begin
            state <= state_next;
            if (job_start) begin
                cut_q <= cfg_cutoff;
                max_q <= cfg_max;
                run_q <= cfg_run_cycles;
            end
            if (state == ST_EDGE && edge_valid) begin
                e_i    <= edge_i;
                e_j    <= edge_j;
                e_w    <= edge_w;
                e_last <= edge_last;
            end
            if (state == ST_RUN_START) begin
                run_cnt <= '0;
            end else if (state == ST_RUN_WAIT) begin
                run_cnt <= run_cnt + 32'd1;
            end
        end
    end

    always_comb begin
        state_next = state;
        edge_ready = 1'b0;
        wready     = 1'b0;
        wr_addr    = '0;
        wdata      = '0;
        araddr     = '0;
        case (state)
            ST_IDLE: begin
                if (start) state_next = ST_CFG_CUT;
            end
            ST_CFG_CUT: begin
                wready     = 1'b1;
                wr_addr    = CTR_CUTOFF_ADDR;
                wdata      = cut_q;
                state_next = ST_CFG_MAX;
            end
            ST_CFG_MAX: begin
                wready     = 1'b1;
                wr_addr    = CTR_MAX_ADDR;
                wdata      = max_q;
                state_next = ST_EDGE;
            end
            ST_EDGE: begin
                edge_ready = 1'b1;
                if (edge_valid) state_next = ST_WR_IJ;
            end
            ST_WR_IJ: begin
                wready     = 1'b1;
                wr_addr    = addr_ij;
                wdata      = 32'(e_w);
                state_next = (e_i == e_j) ? after_pair : ST_WR_JI;
            end
            ST_WR_JI: begin
                wready     = 1'b1;
                wr_addr    = addr_ji;
                wdata      = 32'(e_w);
                state_next = after_pair;
            end
`ifdef ISING_HOST_SEQ_VERIFY_EN
            ST_VER_ADDR: begin
                araddr     = addr_ij;
                state_next = ST_VER_CAP;
            end
            ST_VER_CAP: begin
                araddr     = addr_ij;
                state_next = e_last ? ST_RUN_START : ST_EDGE;
            end
`endif
            ST_RUN_START: begin
                wready     = 1'b1;
                wr_addr    = START_ADDR;
                wdata      = START_WORD;
                state_next = ST_RUN_WAIT;
            end
            ST_RUN_WAIT: begin
                if (run_done) state_next = ST_RD_ADDR;
            end
            ST_RD_ADDR: begin
                araddr     = PHASE_ADDR_BASE + (32'(phase_idx) << 2);
                state_next = ST_RD_CAP;
            end
            ST_RD_CAP: begin
                araddr     = PHASE_ADDR_BASE + (32'(phase_idx) << 2);
                state_next = phase_last ? ST_DONE : ST_RD_ADDR;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    ising_phase_reader #(.N(N)) u_phase_reader (
        .clk     (clk),
        .rst_n   (axi_rstn),
        .clear   (job_start),
        .capture (state == ST_RD_CAP),
        .rdata   (rdata),
        .cutoff  (cut_q),
        .index   (phase_idx),
        .last    (phase_last),
        .spins   (spins)
    );

`ifdef ISING_HOST_SEQ_VERIFY_EN
    logic err_q;

    // sticky until reset; a mismatch never aborts the job
    always_ff @(posedge clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            err_q <= 1'b0;
        end else if (state == ST_VER_CAP && rdata[NUM_WEIGHTS-1:0] != e_w) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ising_host_seq.sv
// tb/tb_ising_host_seq.sv - scoreboard bench for ising_host_seq with a behavioural ising_axi register model
`timescale 1ns/1ps
module tb_ising_host_seq;
    import ising_host_seq_pkg::*;

    localparam int N  = 8;
    localparam int NW = 3;

    logic          clk = 1'b0;
    logic          axi_rstn;
    logic [31:0]   cfg_cutoff, cfg_max, cfg_run_cycles;
    logic          start;
    logic          edge_valid, edge_ready, edge_last;
    logic [2:0]    edge_i, edge_j;
    logic [NW-1:0] edge_w;
    logic          wready;
    logic [31:0]   wr_addr, wdata, araddr;
    logic [31:0]   rdata = 32'd0;
    logic          busy, done, err;
    logic [N-1:0]  spins;

    always #5 clk = ~clk;

    ising_host_seq #(.N(N), .NUM_WEIGHTS(NW)) dut (
        .clk            (clk),
        .axi_rstn       (axi_rstn),
        .cfg_cutoff     (cfg_cutoff),
        .cfg_max        (cfg_max),
        .cfg_run_cycles (cfg_run_cycles),
        .start          (start),
        .edge_valid     (edge_valid),
        .edge_ready     (edge_ready),
        .edge_i         (edge_i),
        .edge_j         (edge_j),
        .edge_w         (edge_w),
        .edge_last      (edge_last),
        .wready         (wready),
        .wr_addr        (wr_addr),
        .wdata          (wdata),
        .araddr         (araddr),
        .rdata          (rdata),
        .busy           (busy),
        .done           (done),
        .spins          (spins),
        .err            (err)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    int          checks = 0;
    int          failures = 0;
    wr_t         exp_q[$];
    logic [31:0] obs_addr [512];
    logic [31:0] obs_data [512];
    int          obs_n = 0;
    int          rd_ptr = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          done_cnt = 0;
    int          done_base = 0;
    logic [31:0] wmem [64];
    int          phase_val [N];
    logic        corrupt = 1'b0;

    function automatic logic [5:0] widx(input logic [31:0] a);
        logic [31:0] off;
        off = a - WEIGHT_ADDR_BASE;
        return {off[15:13], off[4:2]};
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (a >= PHASE_ADDR_BASE && a < PHASE_ADDR_BASE + 32'(4 * N))
            return 32'(phase_val[int'((a - PHASE_ADDR_BASE) >> 2)]);
        else if (a >= WEIGHT_ADDR_BASE)
            return wmem[widx(a)] ^ {31'd0, corrupt};
        return 32'd0;
    endfunction

    function automatic logic [31:0] waddr(input int r, input int c);
        return WEIGHT_ADDR_BASE + 32'(r * 4) + 32'(c * 8192);
    endfunction

    // ising_axi register model: writes land in weight memory, reads return one cycle later
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (wready && wr_addr >= WEIGHT_ADDR_BASE) wmem[widx(wr_addr)] <= wdata;
        rdata <= model_read(araddr);
    end

    always @(negedge clk) begin
        if (wready) begin
            obs_addr[obs_n % 512] <= wr_addr;
            obs_data[obs_n % 512] <= wdata;
            obs_n <= obs_n + 1;
            if (wr_addr == START_ADDR && wdata == START_WORD) start_cyc <= cyc;
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic do_check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic drain(input int remain);
        wr_t e;
        while (rd_ptr < obs_n) begin
            do_check("write_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                do_check("wr_addr", obs_addr[rd_ptr % 512], e.addr);
                do_check("wdata", obs_data[rd_ptr % 512], e.data);
            end
            rd_ptr++;
        end
        do_check("pending_writes", 32'(exp_q.size()), 32'(remain));
        exp_q.delete();
    endtask

    task automatic start_job(input logic [31:0] cut, input logic [31:0] mx, input logic [31:0] run);
        cfg_cutoff     = cut;
        cfg_max        = mx;
        cfg_run_cycles = run;
        push_wr(CTR_CUTOFF_ADDR, cut);
        push_wr(CTR_MAX_ADDR, mx);
        done_base = done_cnt;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        do_check("cfg_cut_wready", 32'(wready), 32'd1);
        do_check("cfg_cut_addr", wr_addr, CTR_CUTOFF_ADDR);
        @(negedge clk);
        do_check("cfg_max_wready", 32'(wready), 32'd1);
        do_check("cfg_max_addr", wr_addr, CTR_MAX_ADDR);
    endtask

    task automatic send_edge(input int i, input int j, input int w, input logic last);
        logic got;
        push_wr(waddr(i, j), 32'(w));
        if (i != j) push_wr(waddr(j, i), 32'(w));
        if (last) push_wr(START_ADDR, 32'h10);
        edge_i     = 3'(i);
        edge_j     = 3'(j);
        edge_w     = NW'(w);
        edge_last  = last;
        edge_valid = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (edge_ready) begin
                got = 1'b1;
                break;
            end
        end
        do_check("edge_accept", 32'(got), 32'd1);
        @(posedge clk);
        #1 edge_valid = 1'b0;
    endtask

    task automatic finish_job(input int run, input logic [31:0] cut);
        logic        seen;
        logic [N-1:0] exp_spins;
        seen = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (araddr == PHASE_ADDR_BASE) begin
                seen = 1'b1;
                break;
            end
        end
        do_check("phase_read_start", 32'(seen), 32'd1);
        do_check("run_length", 32'(cyc - start_cyc), 32'((run == 0) ? 2 : run + 1));
        seen = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        do_check("done_seen", 32'(seen), 32'd1);
        repeat (3) @(negedge clk);
        #1;
        do_check("done_pulses", 32'(done_cnt - done_base), 32'd1);
        do_check("busy_after_done", 32'(busy), 32'd0);
        do_check("araddr_idle", araddr, 32'd0);
        for (int k = 0; k < N; k++) exp_spins[N - 1 - k] = (32'(phase_val[k]) >= cut);
        do_check("spins", 32'(spins), 32'(exp_spins));
        drain(0);
    endtask

    task automatic check_all_zero(input string tag);
        do_check({tag, "_busy"}, 32'(busy), 32'd0);
        do_check({tag, "_done"}, 32'(done), 32'd0);
        do_check({tag, "_wready"}, 32'(wready), 32'd0);
        do_check({tag, "_wr_addr"}, wr_addr, 32'd0);
        do_check({tag, "_wdata"}, wdata, 32'd0);
        do_check({tag, "_araddr"}, araddr, 32'd0);
        do_check({tag, "_edge_ready"}, 32'(edge_ready), 32'd0);
        do_check({tag, "_spins"}, 32'(spins), 32'd0);
        do_check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        axi_rstn = 1'b0;
        start = 1'b0;
        edge_valid = 1'b0;
        edge_last = 1'b0;
        edge_i = '0;
        edge_j = '0;
        edge_w = '0;
        cfg_cutoff = '0;
        cfg_max = '0;
        cfg_run_cycles = '0;
        repeat (3) @(posedge clk);
        #1 check_all_zero("reset");
        axi_rstn = 1'b1;
        @(negedge clk);

        // five-node maxcut A..E = 0..4, ancilla H = 5
        phase_val = '{6, 1, 7, 5, 2, 6, 4, 3};
        start_job(32'd4, 32'd8, 32'd1000);
        send_edge(0, 1, 0, 1'b0);
        send_edge(0, 4, 0, 1'b0);
        send_edge(1, 2, 0, 1'b0);
        send_edge(1, 3, 0, 1'b0);
        send_edge(2, 3, 0, 1'b0);
        send_edge(3, 4, 0, 1'b0);
        for (int n = 0; n < 5; n++) send_edge(n, 5, 2, 1'b0);
        send_edge(0, 0, 1, 1'b1);
        repeat (20) @(negedge clk);
        cfg_cutoff = 32'd99;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        finish_job(1000, 32'd4);
        do_check("maxcut_spins", 32'(spins), 32'h0000_00B6);
        repeat (5) @(negedge clk);
        do_check("spins_hold", 32'(spins), 32'h0000_00B6);

        phase_val = '{6, 1, 7, 5, 2, 6, 4, 3};
        start_job(32'd6, 32'd2, 32'd0);
        send_edge(2, 2, 3, 1'b1);
        finish_job(0, 32'd6);

        start_job(32'd4, 32'd8, 32'd5);
        send_edge(1, 2, 3, 1'b0);
        @(posedge clk);
        #1 axi_rstn = 1'b0;
        #1 check_all_zero("midjob_reset");
        @(posedge clk);
        @(posedge clk);
        #1 axi_rstn = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        do_check("idle_after_reset", 32'(busy), 32'd0);
        drain(1);

        phase_val = '{0, 9, 3, 3, 10, 2, 8, 1};
        start_job(32'd3, 32'd9, 32'd10);
        send_edge(1, 2, 3, 1'b0);
        send_edge(3, 3, 5, 1'b1);
        finish_job(10, 32'd3);

`ifdef ISING_HOST_SEQ_VERIFY_EN
        corrupt = 1'b1;
        start_job(32'd4, 32'd8, 32'd3);
        send_edge(4, 5, 2, 1'b1);
        finish_job(3, 32'd4);
        do_check("err_set", 32'(err), 32'd1);
        corrupt = 1'b0;
        start_job(32'd4, 32'd8, 32'd3);
        send_edge(6, 7, 1, 1'b1);
        finish_job(3, 32'd4);
        do_check("err_sticky", 32'(err), 32'd1);
`else
        do_check("err_tied_low", 32'(err), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
